// File: rtl/decoder_scan_ctrl.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with two sources for the index.
// In direct mode the index is an externally strobed select value. In scan mode
// an internal divided counter walks through every output and pulses wrap
// whenever it returns to index 0.
module decoder_scan_ctrl #(
    parameter  int SEL_W      = 3,
    parameter  int SCAN_DIV   = 4,
    parameter  int ACTIVE_LOW = 0,
    localparam int OUT_N      = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    output logic [OUT_N-1:0] out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             out_valid,
    output logic             wrap
);

    // The divider needs at least one bit, even when SCAN_DIV is 1.
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(OUT_N - 1);

    // Inactive pattern. XOR-ing a one-hot vector with it gives the
    // decoded pattern in either polarity.
    localparam logic [OUT_N-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] div_reg;

    function automatic logic [OUT_N-1:0] decode(input logic [SEL_W-1:0] idx);
        logic [OUT_N-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot ^ INACTIVE;
    endfunction

    // Controller: reset and disable come first, then scan or direct behaviour.
    // All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            out       <= INACTIVE;
            cur_sel   <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            div_reg   <= '0;
        end else if (!en) begin
            // cur_sel is left alone so the last index remains observable.
            state_reg <= IDLE;
            out       <= INACTIVE;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            div_reg   <= '0;
        end else if (mode) begin
            wrap <= 1'b0;
            if (state_reg != SCAN) begin
                // Entry from IDLE or DIRECT always restarts at index 0.
                // wrap is not raised on entry.
                state_reg <= SCAN;
                cur_sel   <= '0;
                out       <= decode('0);
                out_valid <= 1'b1;
                div_reg   <= '0;
            end else if (div_reg == DIV_LAST) begin
                div_reg   <= '0;
                cur_sel   <= cur_sel + SEL_W'(1);
                out       <= decode(cur_sel + SEL_W'(1));
                out_valid <= 1'b1;
                wrap      <= (cur_sel == SEL_LAST);
            end else begin
                div_reg <= div_reg + DIV_W'(1);
            end
        end else begin
            state_reg <= DIRECT;
            wrap      <= 1'b0;
            div_reg   <= '0;
            if (sel_valid) begin
                // A strobe is accepted on the entry cycle as well.
                cur_sel   <= sel;
                out       <= decode(sel);
                out_valid <= 1'b1;
            end else if (state_reg != DIRECT) begin
                // Direct mode starts blank until the first strobe arrives.
                out       <= INACTIVE;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Scoreboard bench for decoder_scan_ctrl. Two configurations run side by side
// on the same stimulus:
//   dut_a: SEL_W=3, SCAN_DIV=4, active high
//   dut_b: SEL_W=2, SCAN_DIV=1, active low
module tb_decoder_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, mode, sel_valid;
    logic [2:0] sel_a;
    logic [1:0] sel_b;
    assign sel_b = sel_a[1:0];

    logic [7:0] out_a;
    logic [2:0] cur_sel_a;
    logic       out_valid_a, wrap_a;
    logic [3:0] out_b;
    logic [1:0] cur_sel_b;
    logic       out_valid_b, wrap_b;

    decoder_scan_ctrl #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_a),
        .sel_valid(sel_valid), .out(out_a), .cur_sel(cur_sel_a),
        .out_valid(out_valid_a), .wrap(wrap_a)
    );

    decoder_scan_ctrl #(.SEL_W(2), .SCAN_DIV(1), .ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel_b),
        .sel_valid(sel_valid), .out(out_b), .cur_sel(cur_sel_b),
        .out_valid(out_valid_b), .wrap(wrap_b)
    );

    typedef struct packed {
        logic [7:0] out;
        logic [2:0] cs;
        logic       v;
        logic       w;
    } exp_t;

    exp_t  q_a[$];
    exp_t  q_b[$];
    string q_ph[$];
    string phase = "reset";
    int    checks = 0;
    int    passed = 0;

    // Reference model, indexed by DUT (0 = a, 1 = b).
    // m_st: 0 idle, 1 direct, 2 scan
    // m_t:  cycles elapsed since scan entry
    int m_st[2];
    int m_t[2];
    int m_idx[2];
    bit m_valid[2];
    bit m_wrap[2];

    task automatic model_step(input int k, input bit r, input bit e, input bit md,
                              input bit sv, input int s, output exp_t x);
        int n;
        int dv;
        bit al;
        logic [7:0] mask;
        logic [7:0] pat;
        n  = (k == 0) ? 8 : 4;
        dv = (k == 0) ? 4 : 1;
        al = (k == 1);
        m_wrap[k] = 1'b0;
        if (!r) begin
            m_st[k] = 0; m_idx[k] = 0; m_valid[k] = 1'b0;
        end else if (!e) begin
            m_st[k] = 0; m_valid[k] = 1'b0;
        end else if (md) begin
            if (m_st[k] != 2) begin
                m_st[k] = 2;
                m_t[k] = 0;
            end else begin
                m_t[k]++;
            end
            m_idx[k]   = (m_t[k] / dv) % n;
            m_valid[k] = 1'b1;
            m_wrap[k]  = (m_t[k] > 0) && (m_t[k] % (dv * n) == 0);
        end else begin
            if (sv) begin
                m_idx[k] = s % n;
                m_valid[k] = 1'b1;
            end else if (m_st[k] != 1) begin
                m_valid[k] = 1'b0;
            end
            m_st[k] = 1;
        end
        mask = (n == 8) ? 8'hFF : 8'h0F;
        pat  = m_valid[k] ? (8'd1 << m_idx[k]) : 8'd0;
        if (al) pat = ~pat & mask;
        x.out = pat;
        x.cs  = 3'(m_idx[k]);
        x.v   = m_valid[k];
        x.w   = m_wrap[k];
    endtask

    // One clock of stimulus. The expected post-edge outputs are queued first.
    task automatic cyc(input bit r, input bit e, input bit md, input bit sv, input int s);
        exp_t xa;
        exp_t xb;
        rst_n = r; en = e; mode = md; sel_valid = sv; sel_a = 3'(s);
        model_step(0, r, e, md, sv, s, xa);
        model_step(1, r, e, md, sv, s, xb);
        q_a.push_back(xa);
        q_b.push_back(xb);
        q_ph.push_back(phase);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every edge produces a new registered output word on both DUTs.
    exp_t  ea;
    exp_t  eb;
    string ph;
    always @(posedge clk) begin
        #2;
        if (q_a.size() > 0 && q_b.size() > 0 && q_ph.size() > 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            ph = q_ph.pop_front();
            checks++;
            if ({out_a, cur_sel_a, out_valid_a, wrap_a} == ea) passed++;
            else $display("FAIL dut_a %s t=%0t: out=%h cur_sel=%0d valid=%b wrap=%b, expected out=%h cur_sel=%0d valid=%b wrap=%b",
                          ph, $time, out_a, cur_sel_a, out_valid_a, wrap_a, ea.out, ea.cs, ea.v, ea.w);
            checks++;
            if ({4'h0, out_b, 1'b0, cur_sel_b, out_valid_b, wrap_b} == eb) passed++;
            else $display("FAIL dut_b %s t=%0t: out=%h cur_sel=%0d valid=%b wrap=%b, expected out=%h cur_sel=%0d valid=%b wrap=%b",
                          ph, $time, out_b, cur_sel_b, out_valid_b, wrap_b, eb.out, eb.cs, eb.v, eb.w);
        end
    end

    initial begin
        bit mode_r;
        bit r_r;
        bit e_r;
        bit sv_r;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel_a = '0;

        phase = "reset";
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        phase = "direct_sweep";
        for (int s = 0; s < 8; s++) begin
            cyc(1, 1, 0, 1, s);
            repeat (9) cyc(1, 1, 0, 0, int'($urandom_range(0, 7)));
        end

        phase = "scan_wrap";
        repeat (40) cyc(1, 1, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));

        phase = "disable";
        repeat (3) cyc(1, 0, 1'($urandom_range(0, 1)), 0, 0);

        phase = "mode_switch";
        for (int i = 0; i < 100; i++) begin
            if (m_st[0] == 2 && m_idx[0] == 5) break;
            cyc(1, 1, 1, 0, 0);
        end
        cyc(1, 1, 0, 1, 2);
        repeat (3) cyc(1, 1, 0, 0, int'($urandom_range(0, 7)));
        repeat (10) cyc(1, 1, 1, 0, 0);

        phase = "reset_mid_scan";
        for (int i = 0; i < 100; i++) begin
            if (m_st[0] == 2 && m_idx[0] == 6) break;
            cyc(1, 1, 1, 0, 0);
        end
        cyc(0, 1, 1, 0, 0);
        repeat (12) cyc(1, 1, 1, 0, 0);

        phase = "random";
        mode_r = 1'b0;
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) mode_r = ~mode_r;
            e_r  = ($urandom_range(0, 15) != 0);
            r_r  = ($urandom_range(0, 63) != 0);
            sv_r = ($urandom_range(0, 2) == 0);
            cyc(r_r, e_r, mode_r, sv_r, int'($urandom_range(0, 7)));
        end

        phase = "drain";
        cyc(1, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        checks++;
        if (q_a.size() == 0 && q_b.size() == 0) passed++;
        else $display("FAIL drain: pending entries a=%0d b=%0d, expected 0", q_a.size(), q_b.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Registered, parametrised SEL_W-to-2^SEL_W one-hot decoder. Successor to the fixed combinational 3-to-8 decoder.
- Direct mode: an externally supplied select is latched on a valid strobe and decoded.
- Scan mode: an internal divided counter steps the select through all outputs, with a wrap pulse. Used for row/digit-select and round-robin enable generation.

Parameters:
- SEL_W, 3, select width; legal 1..6.
- OUT_N, 2**SEL_W, number of decoded outputs; derived, not overridden.
- SCAN_DIV, 4, clock cycles each output is held in scan mode; legal >= 1.
- ACTIVE_LOW, 0, 0: selected output = 1, others 0; 1: selected output = 0, others 1 (inactive pattern inverted likewise).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  block enable; low forces the inactive output pattern.
- mode  in  1  0 = direct, 1 = scan.
- sel  in  SEL_W  direct-mode select value.
- sel_valid  in  1  strobe: latch sel this cycle (direct mode only).
- out  out  OUT_N  registered decoded output.
- cur_sel  out  SEL_W  index currently decoded onto out.
- out_valid  out  1  high when out carries a decoded pattern.
- wrap  out  1  one-cycle pulse when scan index wraps OUT_N-1 -> 0.

Behaviour:
- All outputs registered. Nothing is combinational from inputs to outputs.
- Reset (rst_n=0 at a clk edge), highest priority, also mid-scan:
  - state=IDLE, out=inactive pattern (all 0, or all 1 if ACTIVE_LOW), cur_sel=0, out_valid=0, wrap=0, divider=0.
- Inactive pattern = all OUT_N bits deasserted. Decoded pattern = only bit cur_sel asserted.
- States: IDLE, DIRECT, SCAN.
- en=0 in any state:
  - Next state IDLE; out inactive, out_valid=0, wrap=0.
  - cur_sel holds its last value.
- IDLE with en=1:
  - mode=0 -> DIRECT.
  - mode=1 -> SCAN.
- DIRECT entry: out inactive and out_valid=0 until the first sel_valid. A sel_valid in the entry cycle itself is honoured.
- DIRECT, sel_valid=1 at edge k:
  - At edge k+1: cur_sel=sel, out=decode(sel), out_valid=1. Latency is one cycle.
  - Value holds until the next sel_valid. Back-to-back strobes update every cycle.
- SCAN entry, from IDLE or DIRECT: the next edge sets cur_sel=0, out=decode(0), out_valid=1, divider=0. sel_valid is ignored.
- SCAN step:
  - divider counts 0..SCAN_DIV-1. At terminal count, cur_sel increments and divider clears.
  - Each index is therefore held exactly SCAN_DIV cycles.
  - SCAN_DIV=1 steps every cycle.
- SCAN wrap: the increment from OUT_N-1 returns to 0. wrap=1 for exactly the cycle in which cur_sel first shows 0 after the wrap. wrap is not asserted on scan entry.
- mode 1->0 while en=1:
  - Next state DIRECT; out goes inactive and out_valid=0 on the next edge.
  - If sel_valid=1 in that same cycle, sel is latched and decoded instead.
- mode 0->1 while en=1: restart scan at index 0 as on SCAN entry.
- Invariant: at most one out bit asserted at any time.
- Invariant: out_valid=0 implies out is the inactive pattern.

Test Plan:
- Reset: SEL_W=3, ACTIVE_LOW=0; rst_n=0 for 2 cycles, then 1 with en=0 -> out=8'h00, cur_sel=0, out_valid=0, wrap=0.
- Direct sweep: en=1, mode=0; apply sel=0..7 with sel_valid=1 on each, 10 cycles apart -> one cycle later out = 8'h01, 8'h02, ... 8'h80; cur_sel matches; out_valid=1.
- Scan wrap: mode=1, SCAN_DIV=4 -> cur_sel holds each of 0..7 for 4 cycles; wrap=1 for one cycle when cur_sel returns to 0 after 32 cycles; out=8'h01 then.
- Active-low with SCAN_DIV=1: SEL_W=2, ACTIVE_LOW=1 -> out cycles 4'b1110, 1101, 1011, 0111 every cycle; wrap every 4th cycle; en=0 gives 4'b1111.
- Mode switch: mid-scan at cur_sel=5, set mode=0 with sel=2, sel_valid=1 -> next edge out=8'h04, cur_sel=2, no wrap. Switching back to mode=1 restarts at out=8'h01.
- Reset mid-scan: at cur_sel=6, pulse rst_n=0 for one edge -> out=8'h00, out_valid=0. With en=1, mode=1 held, scan restarts at index 0 with a full SCAN_DIV hold.
